// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: a single signed MAC walks TAPS coefficients against a circular
// sample history for each accepted sample, then rounds, saturates and registers the result.
`timescale 1ns/1ps
module fir_mac_sequencer #(
  parameter int TAPS  = 124,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int ACC_W = 40,
  parameter int SHIFT = 15,
  parameter int AW    = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] input_signal,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic signed [DW-1:0] output_signal,
  output logic                 valid_out,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 busy,
  output logic                 overrun,
  output logic [1:0]           dbg_state
);

  // Handshake: a sample is taken on a rising edge where valid_in && ready_in; ready_in is
  // high only in IDLE, and a sample offered while ready_in is low is dropped and sets overrun.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2
  } state_e;

  localparam logic [AW-1:0]          K_LAST  = AW'(TAPS - 1);
  localparam logic [AW:0]            TAPS_W  = (AW + 1)'(TAPS);
  localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_e state_q, state_d;

  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]     out_q, out_d;
  logic                     vout_q, vout_d;
  logic                     overrun_q, overrun_d;

  logic signed [DW-1:0]     hist_q [TAPS];
  logic signed [CW-1:0]     coef_q [TAPS];

  logic                     accept;
  logic                     mac_en;
  logic                     round_en;
  logic                     coef_wr;
  logic signed [DW+CW-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd_shr;
  logic signed [DW-1:0]     sat_val;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_in) state_d = S_MAC;
      S_MAC:   if (k_q == K_LAST) state_d = S_ROUND;
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    ready_in  = (state_q == S_IDLE);
    busy      = !ready_in;
    accept    = valid_in && ready_in;
    mac_en    = (state_q == S_MAC);
    round_en  = (state_q == S_ROUND);
    coef_wr   = coef_we && ready_in && ({1'b0, coef_addr} < TAPS_W);
    dbg_state = state_q;
  end

  // MAC datapath and output rounding/saturation
  always_comb begin
    prod     = coef_q[k_q] * hist_q[rd_ptr_q];
    prod_ext = {{(ACC_W-DW-CW){prod[DW+CW-1]}}, prod};
    rnd_sum  = acc_q + HALF;
    rnd_shr  = rnd_sum >>> SHIFT;
    if (rnd_shr > OUT_MAX)      sat_val = OUT_MAX[DW-1:0];
    else if (rnd_shr < OUT_MIN) sat_val = OUT_MIN[DW-1:0];
    else                        sat_val = rnd_shr[DW-1:0];

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    k_d       = k_q;
    acc_d     = acc_q;
    out_d     = out_q;
    vout_d    = 1'b0;
    overrun_d = overrun_q | (valid_in & ~ready_in);

    if (accept) begin
      acc_d    = '0;
      k_d      = '0;
      rd_ptr_d = wr_ptr_q;
    end
    if (mac_en) begin
      acc_d    = acc_q + prod_ext;
      k_d      = k_q + AW'(1);
      // History is walked newest-to-oldest, so the read pointer runs backwards.
      rd_ptr_d = (rd_ptr_q == '0) ? K_LAST : rd_ptr_q - AW'(1);
    end
    if (round_en) begin
      out_d    = sat_val;
      vout_d   = 1'b1;
      wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      vout_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      vout_q    <= vout_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[wr_ptr_q] <= input_signal;
    end
  end

  // A write in the same IDLE cycle as an accept lands before that sample's first MAC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign output_signal = out_q;
  assign valid_out     = vout_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: directed and random samples against a
// convolution model over the full sample history since reset.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;

  localparam int TAPS  = 124;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int ACC_W = 40;
  localparam int SHIFT = 15;
  localparam int AW    = $clog2(TAPS);
  localparam longint YMAX = (longint'(1) << (DW - 1)) - 1;
  localparam longint YMIN = -(longint'(1) << (DW - 1));

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] input_signal = '0;
  logic                 valid_in = 1'b0;
  logic                 ready_in;
  logic signed [DW-1:0] output_signal;
  logic                 valid_out;
  logic                 coef_we = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_data = '0;
  logic                 busy;
  logic                 overrun;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .TAPS(TAPS), .DW(DW), .CW(CW), .ACC_W(ACC_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .input_signal(input_signal), .valid_in(valid_in), .ready_in(ready_in),
    .output_signal(output_signal), .valid_out(valid_out),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DW-1:0] exp_q[$];
  int mdl_h[TAPS];
  int x_hist[$];

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_y();
    longint acc = 0;
    longint r;
    int n = x_hist.size();
    for (int k = 0; k < TAPS; k++)
      if (k < n) acc += longint'(mdl_h[k]) * longint'(x_hist[n - 1 - k]);
    r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (r > YMAX) r = YMAX;
    if (r < YMIN) r = YMIN;
    return r[DW-1:0];
  endfunction

  function automatic void model_accept(input int x);
    x_hist.push_back(x);
    if (x_hist.size() > TAPS) void'(x_hist.pop_front());
    exp_q.push_back(model_y());
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    valid_in = 1'b0;
    coef_we = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < TAPS; i++) mdl_h[i] = 0;
    x_hist.delete();
    exp_q.delete();
    rst = 1'b1;
    tick();
    check_eq("rst_out", output_signal, 0);
    check_eq("rst_vout", valid_out, 0);
    check_eq("rst_ready", ready_in, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overrun", overrun, 0);
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we = 1'b1;
    coef_addr = AW'(addr);
    coef_data = CW'(data);
    if (addr < TAPS) mdl_h[addr] = data;
    tick();
    coef_we = 1'b0;
  endtask

  // One sample end to end; optional coefficient write in the accept cycle, and
  // optional attempted write (addr 0) during MAC that must be ignored.
  task automatic run_sample(input int x, input bit with_coef, input int caddr,
                            input int cdata, input bit mid_we);
    int w = 0;
    int cnt = 0;
    logic signed [DW-1:0] e;
    while (!ready_in && w < TAPS + 10) begin
      tick();
      w++;
    end
    check_eq("ready_before", ready_in, 1);
    valid_in = 1'b1;
    input_signal = DW'(x);
    if (with_coef) begin
      coef_we = 1'b1;
      coef_addr = AW'(caddr);
      coef_data = CW'(cdata);
      mdl_h[caddr] = cdata;
    end
    model_accept(x);
    tick();
    valid_in = 1'b0;
    coef_we = 1'b0;
    check_eq("busy_mac", busy, 1);
    coef_addr = '0;
    coef_data = CW'(int'($urandom_range(0, 65535)));
    while (!valid_out && cnt < TAPS + 10) begin
      coef_we = mid_we && (cnt == 5);
      tick();
      cnt++;
    end
    coef_we = 1'b0;
    e = exp_q.pop_front();
    check_eq("latency", cnt, TAPS + 1);
    check_eq("out", output_signal, e);
    check_eq("ready_at_vout", ready_in, 1);
    tick();
    check_eq("vout_pulse", valid_out, 0);
    check_eq("out_hold", output_signal, e);
  endtask

  task automatic run_plain(input int x);
    run_sample(x, 1'b0, 0, 0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int last_acc;
    int pulses;
    int w;
    bit dropped;
    logic signed [DW-1:0] e;

    // reset and zero coefficients
    apply_reset();
    run_plain(1000);

    // impulse
    apply_reset();
    write_coef(0, 16384);
    write_coef(1, -8192);
    run_plain(1000); run_plain(0); run_plain(0);

    // saturation
    apply_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < 6; i++) run_plain(32767);
    for (int i = 0; i < 6; i++) run_plain(-32768);

    // rounding half up
    apply_reset();
    write_coef(0, 1);
    run_plain(16384);
    run_plain(-16384);

    // history wrap-around
    apply_reset();
    write_coef(TAPS - 1, 16384);
    for (int n = 0; n <= TAPS + 4; n++) run_plain(2 * n);

    // back-pressure with continuous valid_in
    apply_reset();
    write_coef(0, 16384);
    write_coef(1, -8192);
    check_eq("bp_overrun_pre", overrun, 0);
    last_acc = -1;
    dropped = 1'b0;
    valid_in = 1'b1;
    for (int c = 0; c < 3 * (TAPS + 2) + 4; c++) begin
      if (valid_out) begin
        check_eq("bp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("bp_out", output_signal, e);
        end
      end
      input_signal = DW'(3 * c);
      if (ready_in) begin
        model_accept(3 * c);
        if (last_acc >= 0) check_eq("bp_spacing", c - last_acc, TAPS + 2);
        last_acc = c;
      end else begin
        dropped = 1'b1;
      end
      tick();
      if (dropped) check_eq("bp_overrun", overrun, 1);
    end
    valid_in = 1'b0;
    w = 0;
    while (exp_q.size() > 0 && w < TAPS + 10) begin
      if (valid_out) begin
        e = exp_q.pop_front();
        check_eq("bp_out", output_signal, e);
      end
      tick();
      w++;
    end
    check_eq("bp_drain", exp_q.size(), 0);
    check_eq("bp_overrun_sticky", overrun, 1);

    // write during MAC ignored, write with accept applied
    apply_reset();
    write_coef(0, 16384);
    run_sample(1000, 1'b0, 0, 0, 1'b1);
    run_sample(600, 1'b0, 0, 0, 1'b0);
    run_sample(-2000, 1'b1, 1, 8192, 1'b0);

    // reset abort mid-MAC
    apply_reset();
    write_coef(0, 16384);
    valid_in = 1'b1;
    input_signal = DW'(1234);
    tick();
    valid_in = 1'b0;
    repeat (10) tick();
    apply_reset();
    pulses = 0;
    for (int c = 0; c < TAPS + 5; c++) begin
      if (valid_out) pulses++;
      tick();
    end
    check_eq("abort_no_pulse", pulses, 0);
    write_coef(0, 16384);
    write_coef(1, -8192);
    run_plain(1000); run_plain(0); run_plain(0);

    // randomized coefficients and samples
    apply_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < 24; i++) begin
      run_sample(int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, TAPS - 1)),
                 int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR engine: one shared signed multiplier/accumulator sequenced over TAPS coefficients per input sample, replacing the fully parallel tap array where area matters more than throughput. Sits between the sample source and downstream consumer with the same `input_signal`/`valid_in` → `output_signal`/`valid_out` framing as `fir_filter`, adds a `ready_in` back-pressure signal, and provides a run-time coefficient load port. Contains the FSM, circular sample history, coefficient register file, MAC and output rounding/saturation.

## Interface
- TAPS, 124, number of filter taps (≥2)
- DW, 16, sample width, signed two's complement
- CW, 16, coefficient width, signed Q1.(CW-1)
- ACC_W, 40, accumulator width (≥ DW+CW+$clog2(TAPS))
- SHIFT, 15, right shift applied to accumulator before output
- AW, $clog2(TAPS), coefficient/history address width (derived)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- input_signal  in  DW  new sample, signed
- valid_in  in  1  sample present
- ready_in  out  1  block can accept a sample this cycle
- output_signal  out  DW  filtered sample, signed, registered
- valid_out  out  1  one-cycle pulse, output_signal valid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  AW  coefficient index k (h[k] multiplies x[n-k])
- coef_data  in  CW  coefficient value, signed
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: sample offered while ready_in=0

## Operation
- FSM states: IDLE, MAC, ROUND. ready_in = (state==IDLE); busy = !ready_in.
- IDLE: on valid_in&&ready_in, write input_signal to history[wr_ptr], clear acc, k←0, rd_ptr←wr_ptr → MAC.
- MAC: each cycle acc += h[k]*history[rd_ptr]; k++; rd_ptr decrements modulo TAPS (0 wraps to TAPS-1). After k=TAPS-1 processed → ROUND.
- ROUND: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic); saturate to [-2^(DW-1), 2^(DW-1)-1]; register to output_signal; pulse valid_out; wr_ptr increments modulo TAPS → IDLE.
- Product is full DW+CW signed; accumulation at ACC_W, no internal saturation.
- valid_in high while ready_in low: sample dropped, overrun←1 (held until reset).
- Coefficient write: applied at clock edge when coef_we=1, busy=0 and coef_addr<TAPS; otherwise ignored (no flag).
- coef_we and an accepted sample in the same IDLE cycle: both take effect; new coefficient is used by that sample's MAC.

## Timing
- Reset (rst=0, async): state=IDLE, wr_ptr=0, acc=0, history and coefficients all 0, output_signal=0, valid_out=0, overrun=0, ready_in=1, busy=0.
- Sample accepted at edge E0; MAC occupies edges E1..E_TAPS; output registered at edge E_TAPS+1; valid_out high for the cycle following, ready_in high again in that same cycle.
- Latency accept→valid_out: TAPS+1 cycles; max throughput one sample per TAPS+2 cycles.
- output_signal holds last value between pulses.
- Reset mid-MAC/ROUND: immediate abort, no valid_out pulse, history cleared.

## Test plan
- Reset: hold rst=0 3 cycles, release → all outputs 0, ready_in=1, busy=0; one sample 1000 with all-zero coefficients → valid_out after TAPS+1 cycles with output 0.
- Impulse: h[0]=16384, h[1]=-8192, rest 0; samples 1000,0,0 → outputs 500, -250, 0, each valid_out exactly TAPS+1 cycles after its accept.
- Saturation/rounding: all h=32767, repeated 32767 → output pins 32767; repeated -32768 → -32768; h[0]=1, x=16384 → 1 (half rounds up), x=-16384 → 0.
- Wrap-around: only h[TAPS-1]=16384; ramp x[n]=2n for n=0..TAPS+4 → outputs 0 for n<TAPS-1, then x[n-TAPS+1]/2 = 0,1,2,…,5.
- Back-pressure: valid_in held high continuously with ramp data → one accept per TAPS+2 cycles, overrun=1 from first drop, accepted samples unaffected.
- Config/abort: coef_we during MAC → h unchanged, result matches old coefficients; rst=0 at MAC cycle 10 → valid_out never pulses, next impulse test reproduces fresh-reset outputs.
